tile_order_shuffler: RTL

- Generates a uniformly shuffled permutation of board tile positions 0..N-1 for the game board.
- Uses a free-running 16-bit LFSR and an iterative Fisher-Yates shuffle with rejection sampling.
- Successor to the fixed-table order generator. N and index width are parameters, so the edge ring (N=24) and the centre tiles (N=12) each use one instance.
- Sits between the game FSM, which issues start and seed_load, and the tile renderer / board-state logic, which consume order.

---
 rtl/tile_order_shuffler_if.sv | 42 ++++
 rtl/tile_order_shuffler.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tile_order_shuffler_if.sv
// tile_order_shuffler_if
// Groups the request/response signals between the game FSM (master) and a
// tile_order_shuffler instance (slave).
//   start      master -> slave  1-cycle shuffle request, honoured only when idle
//   seed_load  master -> slave  mix seed_in into the LFSR this cycle
//   seed_in    master -> slave  16-bit entropy word
//   busy       slave -> master  shuffle in progress
//   done       slave -> master  1-cycle pulse, order is being updated
//   valid      slave -> master  at least one shuffle has completed
//   order      slave -> master  packed permutation, slot k at order[k*W +: W]
interface tile_order_shuffler_if #(
    parameter int unsigned N = 24,
    parameter int unsigned W = 5
);
    logic           start;
    logic           seed_load;
    logic [15:0]    seed_in;
    logic           busy;
    logic           done;
    logic           valid;
    logic [N*W-1:0] order;

    modport master (
        output start,
        output seed_load,
        output seed_in,
        input  busy,
        input  done,
        input  valid,
        input  order
    );

    modport slave (
        input  start,
        input  seed_load,
        input  seed_in,
        output busy,
        output done,
        output valid,
        output order
    );
endinterface

// File: rtl/tile_order_shuffler.sv
// tile_order_shuffler
// Produces a uniformly shuffled permutation of tile slots 0..N-1. A free-running
// 16-bit Galois LFSR supplies one candidate index per cycle; an iterative
// Fisher-Yates shuffle consumes it, rejecting candidates larger than the
// current position so every accepted swap partner is uniformly distributed.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  tile_order_shuffler_if.slave (start/seed_load/seed_in in;
//        busy/done/valid/order out)
module tile_order_shuffler #(
    parameter int unsigned N    = 24,
    parameter int unsigned W    = 5,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic                  clk,
    input logic                  rst,
    tile_order_shuffler_if.slave bus
);

    localparam logic [15:0]  LfsrTaps     = 16'hB400;
    localparam logic [15:0]  LfsrFallback = 16'hACE1;
    // An all-zero LFSR would lock up, so a zero seed falls back to the default.
    localparam logic [15:0]  LfsrInit     = (SEED == 16'h0000) ? LfsrFallback : SEED;
    localparam logic [W-1:0] LastIdx      = W'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StShuffle,
        StDone
    } state_e;

    state_e       state_q, state_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [15:0]  lfsr_step;
    logic [15:0]  lfsr_mix;
    logic [W-1:0] perm_q  [N];
    logic [W-1:0] perm_d  [N];
    logic [W-1:0] order_q [N];
    logic [W-1:0] order_d [N];
    logic [W-1:0] i_q, i_d;
    logic         valid_q, valid_d;
    logic [W-1:0] r;
    logic         accept;

    // ------------------------------------------------------------------
    // LFSR: steps every cycle in every state; seed_load replaces the step
    // with an XOR mix so button timing perturbs the sequence.
    // ------------------------------------------------------------------
    always_comb begin
        lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
        lfsr_mix  = lfsr_q ^ bus.seed_in;
        if (bus.seed_load) begin
            lfsr_d = (lfsr_mix == 16'h0000) ? LfsrFallback : lfsr_mix;
        end else begin
            lfsr_d = lfsr_step;
        end
    end

    // Candidate swap partner comes from the current (pre-update) LFSR value.
    assign r      = lfsr_q[W-1:0];
    assign accept = (r <= i_q);

    // ------------------------------------------------------------------
    // Shuffle FSM, next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        perm_d  = perm_q;
        order_d = order_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StInit;
                end
            end

            StInit: begin
                for (int unsigned k = 0; k < N; k++) begin
                    perm_d[k] = W'(k);
                end
                i_d     = LastIdx;
                state_d = StShuffle;
            end

            StShuffle: begin
                // Out-of-range candidates are rejected; the next LFSR value is
                // tried on the following cycle, keeping the draw uniform.
                if (accept) begin
                    // Both reads use the old array, so r == i leaves it intact
                    // and the contents remain a permutation every cycle.
                    perm_d[i_q] = perm_q[r];
                    perm_d[r]   = perm_q[i_q];
                    if (i_q == W'(1)) begin
                        state_d = StDone;
                    end else begin
                        i_d = i_q - W'(1);
                    end
                end
            end

            StDone: begin
                order_d = perm_q;
                valid_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            lfsr_q  <= LfsrInit;
            i_q     <= '0;
            valid_q <= 1'b0;
            for (int unsigned k = 0; k < N; k++) begin
                perm_q[k]  <= W'(k);
                order_q[k] <= W'(k);
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            i_q     <= i_d;
            valid_q <= valid_d;
            perm_q  <= perm_d;
            order_q <= order_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);
    assign bus.valid = valid_q;

    for (genvar k = 0; k < N; k++) begin : gen_pack
        assign bus.order[k*W +: W] = order_q[k];
    end

endmodule
